conv_accumulator: RTL and testbench
===================================

# conv_accumulator

Pipelined multi-operand adder tree followed by a windowed accumulator, parametrised in operand width, operand count, accumulator width, signedness and overflow mode. It sits behind the multiplier array of a convolution engine. Each cycle it reduces one beat of NUM_INPUTS products to a single sum. It then accumulates successive beats over a kernel window delimited by first/last tags and emits one result per window. It is streaming-only: there is no backpressure.

## Interface
- WIDTH, 8, bits per input operand
- NUM_INPUTS, 4, operands per beat; power of two, at least 2; LOG2N = clog2(NUM_INPUTS)
- ACC_WIDTH, 16, accumulator and result width; must be at least WIDTH+LOG2N
- SIGNED, 1, 1 = two's complement operands and result, 0 = unsigned
- SATURATE, 0, 1 = clamp on accumulator overflow, 0 = wrap modulo 2^ACC_WIDTH
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  beat qualifier
- in_data  input  NUM_INPUTS*WIDTH  operands; operand k at bits [k*WIDTH +: WIDTH]
- in_first  input  1  beat opens a window (sampled only with in_valid)
- in_last  input  1  beat closes a window (sampled only with in_valid)
- out_valid  output  1  one-cycle pulse; out_sum is a completed window
- out_sum  output  ACC_WIDTH  window result, held until the next out_valid
- out_overflow  output  1  a window overflow occurred; valid with out_valid, held with out_sum

## Operation
- Tree has LOG2N registered levels. Level i adds pairs and grows by one bit, so the tree result is WIDTH+LOG2N bits and exact.
- Operands are sign-extended (SIGNED=1) or zero-extended (SIGNED=0) at the input.
- valid, first and last travel through the tree in a shift register alongside the data.
- Accumulator stage uses two states, IDLE and ACCUM:
  - IDLE plus a tree beat, with or without first: acc = extend(tree_sum) and ovf = 0. A beat without first is an implicit window start. The next state is ACCUM, unless last is set.
  - ACCUM plus a beat with first: the partial result is discarded without output, acc = extend(tree_sum) and ovf = 0.
  - ACCUM plus a beat without first: acc = acc + extend(tree_sum), computed at ACC_WIDTH+1 bits.
    - Overflow is the carry out (unsigned) or an out-of-range result (signed).
    - With SATURATE=1, acc clamps to max or min (unsigned min is 0, max is all ones). With SATURATE=0 it wraps.
    - ovf is sticky per window.
  - Any beat with last loads out_sum with the new acc, loads out_overflow with the new ovf, pulses out_valid and returns to IDLE. first and last together form a single-beat window.
- A cycle without a beat leaves acc, state and outputs unchanged; gaps inside a window are allowed.
- Reset values: every pipeline register is 0, state is IDLE, acc = 0, ovf = 0, out_valid = 0, out_sum = 0, out_overflow = 0.

## Timing
- Latency: a beat sampled at edge t affects the accumulator at edge t+LOG2N+1. For a last beat, out_valid is high for the cycle after edge t+LOG2N+1.
- Throughput is one beat per cycle. Back-to-back single-beat windows give out_valid high every cycle.
- Reset mid-window clears all in-flight beats and the partial sum. The first beat after reset is sampled normally, and no result from before reset ever appears.
- Beats with in_valid=0 are ignored regardless of in_first/in_last.

## Structure
- Shared package conv_pkg holds:
  - a clog2 function
  - the saturation limit constants derived from ACC_WIDTH and SIGNED
  - the IDLE/ACCUM state typedef
- Sub-module adder_tree_level (params IN_WIDTH, PAIRS, SIGNED) is one registered level carrying its valid, first and last bits. It is instantiated LOG2N times by generate.
- The accumulator FSM and the saturation logic live in the top module.

## Test plan
Default parameters unless stated: N=4, W=8, ACC=16, signed, wrap.
- Single window: one beat {1,2,3,4} with first+last at edge 0 -> out_valid for exactly one cycle after edge 3, out_sum=10, out_overflow=0.
- Signed multi-beat: beats {-128 x4}, {1,1,1,1}, {2,2,2,2} with last on the third beat and no first flags -> out_sum=-500, matching the implicit start. A one-cycle in_valid gap inside the window gives the same result.
- Overflow: ACC_WIDTH=12, five beats of {127 x4} (508 each, total 2540):
  - SATURATE=1 -> out_sum=2047, out_overflow=1.
  - SATURATE=0 -> out_sum=-1556, out_overflow=1.
  - The next window {1,0,0,0} -> out_sum=1, out_overflow=0.
- Back-to-back: first+last beats {1,1,1,1}, {2,2,2,2}, {3,3,3,3} on consecutive cycles -> out_valid high for 3 consecutive cycles with 4, 8, 12.
- Restart: first {9,9,9,9}, then first+last {1,2,3,4} -> exactly one out_valid, with out_sum=10.
- Reset mid-window: two beats of {5,5,5,5} with no last, then rst high for one cycle, then first+last {5,5,5,5} -> a single out_valid with out_sum=20. All outputs read 0 during the cycle after the reset edge.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types, constants and helpers for the convolution accumulator datapath.
package conv_pkg;

    localparam int MAX_ACC_WIDTH = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = 1; v < value; v = v * 2) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Limits are returned in a wide container; callers truncate to their accumulator width.
    function automatic logic [MAX_ACC_WIDTH-1:0] sat_max(input int acc_width, input bit is_signed);
        logic [MAX_ACC_WIDTH-1:0] ones;
        ones = '1;
        if (is_signed) begin
            return ones >> (MAX_ACC_WIDTH - acc_width + 1);
        end
        return ones >> (MAX_ACC_WIDTH - acc_width);
    endfunction

    function automatic logic [MAX_ACC_WIDTH-1:0] sat_min(input int acc_width, input bit is_signed);
        logic [MAX_ACC_WIDTH-1:0] one;
        one = 1;
        if (is_signed) begin
            return one << (acc_width - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: sums operand pairs with one bit of growth
// and carries the beat's valid/first/last tags alongside.
module adder_tree_level #(
    parameter int IN_WIDTH = 8,
    parameter int PAIRS    = 2,
    parameter bit SIGNED   = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in_first,
    input  logic                           in_last,
    input  logic [2*PAIRS*IN_WIDTH-1:0]    in_data,
    output logic                           out_valid,
    output logic                           out_first,
    output logic                           out_last,
    output logic [PAIRS*(IN_WIDTH+1)-1:0]  out_data
);

    localparam int OUT_WIDTH = IN_WIDTH + 1;

    logic [PAIRS*OUT_WIDTH-1:0] data_d, data_q;
    logic                       valid_d, valid_q;
    logic                       first_d, first_q;
    logic                       last_d, last_q;

    function automatic logic [OUT_WIDTH-1:0] extend(input logic [IN_WIDTH-1:0] x);
        return {SIGNED & x[IN_WIDTH-1], x};
    endfunction

    always_comb begin
        data_d  = '0;
        valid_d = in_valid;
        first_d = in_first;
        last_d  = in_last;
        for (int p = 0; p < PAIRS; p++) begin
            data_d[p*OUT_WIDTH +: OUT_WIDTH] = extend(in_data[(2*p)*IN_WIDTH +: IN_WIDTH])
                                             + extend(in_data[(2*p+1)*IN_WIDTH +: IN_WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_first = first_q;
    assign out_last  = last_q;

endmodule

// File: rtl/conv_accumulator.sv
// Pipelined multi-operand adder tree feeding a windowed accumulator that emits one
// result per first/last-delimited kernel window.
module conv_accumulator
    import conv_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 4,
    parameter int ACC_WIDTH  = 16,
    parameter bit SIGNED     = 1'b1,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [NUM_INPUTS*WIDTH-1:0]   in_data,
    input  logic                          in_first,
    input  logic                          in_last,
    output logic                          out_valid,
    output logic [ACC_WIDTH-1:0]          out_sum,
    output logic                          out_overflow
);

    localparam int LOG2N      = clog2(NUM_INPUTS);
    localparam int TREE_WIDTH = WIDTH + LOG2N;
    localparam int EXT_WIDTH  = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, SIGNED));
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, SIGNED));

    logic [NUM_INPUTS*WIDTH-1:0] beat_data_d, beat_data_q;
    logic                        beat_valid_d, beat_valid_q;
    logic                        beat_first_d, beat_first_q;
    logic                        beat_last_d, beat_last_q;

    logic [TREE_WIDTH-1:0]       tree_sum;
    logic                        tree_valid;
    logic                        tree_first;
    logic                        tree_last;

    acc_state_e                  state_d, state_q;
    logic [ACC_WIDTH-1:0]        acc_d, acc_q;
    logic                        ovf_d, ovf_q;
    logic                        out_valid_d, out_valid_q;
    logic [ACC_WIDTH-1:0]        out_sum_d, out_sum_q;
    logic                        out_overflow_d, out_overflow_q;

    logic [ACC_WIDTH-1:0]        tree_ext;
    logic [EXT_WIDTH-1:0]        sum_wide;
    logic                        add_ovf;
    logic [ACC_WIDTH-1:0]        acc_next;

    // Input sampling stage; a beat registered here reaches the accumulator LOG2N+1 edges later.
    always_comb begin
        beat_data_d  = in_data;
        beat_valid_d = in_valid;
        beat_first_d = in_first;
        beat_last_d  = in_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_data_q  <= '0;
            beat_valid_q <= 1'b0;
            beat_first_q <= 1'b0;
            beat_last_q  <= 1'b0;
        end else begin
            beat_data_q  <= beat_data_d;
            beat_valid_q <= beat_valid_d;
            beat_first_q <= beat_first_d;
            beat_last_q  <= beat_last_d;
        end
    end

    for (genvar i = 0; i < LOG2N; i++) begin : g_lvl
        localparam int IW = WIDTH + i;
        localparam int P  = NUM_INPUTS >> (i + 1);

        logic [2*P*IW-1:0]   lvl_in;
        logic                lvl_in_valid, lvl_in_first, lvl_in_last;
        logic [P*(IW+1)-1:0] lvl_out;
        logic                lvl_out_valid, lvl_out_first, lvl_out_last;

        if (i == 0) begin : g_head
            assign lvl_in       = beat_data_q;
            assign lvl_in_valid = beat_valid_q;
            assign lvl_in_first = beat_first_q;
            assign lvl_in_last  = beat_last_q;
        end else begin : g_chain
            assign lvl_in       = g_lvl[i-1].lvl_out;
            assign lvl_in_valid = g_lvl[i-1].lvl_out_valid;
            assign lvl_in_first = g_lvl[i-1].lvl_out_first;
            assign lvl_in_last  = g_lvl[i-1].lvl_out_last;
        end

        adder_tree_level #(
            .IN_WIDTH (IW),
            .PAIRS    (P),
            .SIGNED   (SIGNED)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (lvl_in_valid),
            .in_first  (lvl_in_first),
            .in_last   (lvl_in_last),
            .in_data   (lvl_in),
            .out_valid (lvl_out_valid),
            .out_first (lvl_out_first),
            .out_last  (lvl_out_last),
            .out_data  (lvl_out)
        );
    end

    assign tree_sum   = g_lvl[LOG2N-1].lvl_out;
    assign tree_valid = g_lvl[LOG2N-1].lvl_out_valid;
    assign tree_first = g_lvl[LOG2N-1].lvl_out_first;
    assign tree_last  = g_lvl[LOG2N-1].lvl_out_last;

    // One extra bit of headroom makes the true sign (or carry) visible in the top bit.
    always_comb begin
        if (SIGNED) begin
            tree_ext = ACC_WIDTH'($signed(tree_sum));
            sum_wide = EXT_WIDTH'($signed(acc_q)) + EXT_WIDTH'($signed(tree_ext));
            add_ovf  = sum_wide[EXT_WIDTH-1] != sum_wide[EXT_WIDTH-2];
        end else begin
            tree_ext = ACC_WIDTH'(tree_sum);
            sum_wide = EXT_WIDTH'(acc_q) + EXT_WIDTH'(tree_ext);
            add_ovf  = sum_wide[EXT_WIDTH-1];
        end

        acc_next = sum_wide[ACC_WIDTH-1:0];
        if (SATURATE && add_ovf) begin
            acc_next = (SIGNED && sum_wide[EXT_WIDTH-1]) ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        ovf_d          = ovf_q;
        out_valid_d    = 1'b0;
        out_sum_d      = out_sum_q;
        out_overflow_d = out_overflow_q;

        if (tree_valid) begin
            if (state_q == IDLE || tree_first) begin
                acc_d = tree_ext;
                ovf_d = 1'b0;
            end else begin
                acc_d = acc_next;
                ovf_d = ovf_q | add_ovf;
            end

            if (tree_last) begin
                out_valid_d    = 1'b1;
                out_sum_d      = acc_d;
                out_overflow_d = ovf_d;
                state_d        = IDLE;
            end else begin
                state_d        = ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            ovf_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            ovf_q          <= ovf_d;
            out_valid_q    <= out_valid_d;
            out_sum_q      <= out_sum_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// Bench for conv_accumulator: three configurations (16-bit wrap, 12-bit saturate, 12-bit wrap)
// share one stimulus stream and are checked against an arithmetic window model.
module tb_conv_accumulator;

    typedef struct {
        longint sum;
        bit     ovf;
        int     cycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_first;
    logic        in_last;
    logic [31:0] in_data;
    logic [2:0]  out_valid;
    logic [2:0]  out_ovf;
    logic [15:0] sum0;
    logic [11:0] sum1;
    logic [11:0] sum2;

    int cycle = 0;
    int assert_count = 0;
    int fail_count = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int     acc_w[3] = '{16, 12, 12};
    bit     sat_m[3] = '{1'b0, 1'b1, 1'b0};
    longint m_acc[3];
    bit     m_ovf[3];
    bit     m_open[3];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    conv_accumulator #(.WIDTH(8), .NUM_INPUTS(4), .ACC_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_first(in_first),
        .in_last(in_last), .out_valid(out_valid[0]), .out_sum(sum0), .out_overflow(out_ovf[0]));

    conv_accumulator #(.WIDTH(8), .NUM_INPUTS(4), .ACC_WIDTH(12), .SIGNED(1'b1), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_first(in_first),
        .in_last(in_last), .out_valid(out_valid[1]), .out_sum(sum1), .out_overflow(out_ovf[1]));

    conv_accumulator #(.WIDTH(8), .NUM_INPUTS(4), .ACC_WIDTH(12), .SIGNED(1'b1), .SATURATE(1'b0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_first(in_first),
        .in_last(in_last), .out_valid(out_valid[2]), .out_sum(sum2), .out_overflow(out_ovf[2]));

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    function automatic int qSize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qHead(input int d);
        case (d)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic exp_t qPop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void qPush(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic logic [31:0] beat4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Window model: exact integer sum per window, range-checked against the accumulator width.
    task automatic modelBeat(input logic [31:0] data, input bit first, input bit last);
        longint s;
        exp_t   e;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            s += longint'($signed(data[k*8 +: 8]));
        end
        for (int d = 0; d < 3; d++) begin
            longint half;
            longint t;
            half = longint'(1) << (acc_w[d] - 1);
            if (first || !m_open[d]) begin
                m_acc[d] = s;
                m_ovf[d] = 1'b0;
            end else begin
                t = m_acc[d] + s;
                if (t > half - 1 || t < -half) begin
                    m_ovf[d] = 1'b1;
                    if (sat_m[d]) t = (t > 0) ? half - 1 : -half;
                    else          t = ((t + half) % (2 * half) + 2 * half) % (2 * half) - half;
                end
                m_acc[d] = t;
            end
            if (last) begin
                e.sum   = m_acc[d];
                e.ovf   = m_ovf[d];
                e.cycle = cycle + 4;
                qPush(d, e);
                m_open[d] = 1'b0;
            end else begin
                m_open[d] = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input bit valid, input bit first, input bit last, input logic [31:0] data);
        @(negedge clk);
        in_valid = valid;
        in_first = first;
        in_last  = last;
        in_data  = data;
        if (valid) modelBeat(data, first, last);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_valid0"}, out_valid[0], 0);
        checkOutput({tag, "_sum0"}, sum0, 0);
        checkOutput({tag, "_ovf0"}, out_ovf[0], 0);
        checkOutput({tag, "_valid1"}, out_valid[1], 0);
        checkOutput({tag, "_sum1"}, sum1, 0);
        checkOutput({tag, "_ovf1"}, out_ovf[1], 0);
        checkOutput({tag, "_valid2"}, out_valid[2], 0);
        checkOutput({tag, "_sum2"}, sum2, 0);
        checkOutput({tag, "_ovf2"}, out_ovf[2], 0);
    endtask

    // Results due on or after the reset edge never appear; open windows are dropped.
    task automatic applyReset();
        int r;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        r = cycle + 1;
        while (q0.size() > 0 && q0[q0.size()-1].cycle >= r) void'(q0.pop_back());
        while (q1.size() > 0 && q1[q1.size()-1].cycle >= r) void'(q1.pop_back());
        while (q2.size() > 0 && q2[q2.size()-1].cycle >= r) void'(q2.pop_back());
        for (int d = 0; d < 3; d++) m_open[d] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkZero("after_reset");
    endtask

    task automatic monitorDut(input int d, input logic v, input longint sum, input logic ovf);
        exp_t  e;
        string tag;
        tag = $sformatf("dut%0d", d);
        while (qSize(d) > 0 && qHead(d).cycle < cycle) begin
            e = qPop(d);
            checkOutput({tag, "_missed_valid"}, 0, 1);
        end
        if (v === 1'b1) begin
            if (qSize(d) == 0) begin
                checkOutput({tag, "_spurious_valid"}, 1, 0);
            end else begin
                e = qPop(d);
                checkOutput({tag, "_latency"}, cycle, e.cycle);
                checkOutput({tag, "_sum"}, sum, e.sum);
                checkOutput({tag, "_ovf"}, ovf, e.ovf);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            monitorDut(0, out_valid[0], longint'($signed(sum0)), out_ovf[0]);
            monitorDut(1, out_valid[1], longint'($signed(sum1)), out_ovf[1]);
            monitorDut(2, out_valid[2], longint'($signed(sum2)), out_ovf[2]);
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'h0;
        for (int d = 0; d < 3; d++) begin
            m_open[d] = 1'b0;
            m_acc[d]  = 0;
            m_ovf[d]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        checkZero("reset");
        rst = 1'b0;

        applyStimulus(1'b1, 1'b1, 1'b1, beat4(1, 2, 3, 4));
        idle(6);

        applyStimulus(1'b1, 1'b0, 1'b0, beat4(-128, -128, -128, -128));
        applyStimulus(1'b1, 1'b0, 1'b0, beat4(1, 1, 1, 1));
        applyStimulus(1'b1, 1'b0, 1'b1, beat4(2, 2, 2, 2));
        idle(6);

        applyStimulus(1'b1, 1'b0, 1'b0, beat4(-128, -128, -128, -128));
        applyStimulus(1'b1, 1'b0, 1'b0, beat4(1, 1, 1, 1));
        applyStimulus(1'b0, 1'b1, 1'b1, beat4(50, 50, 50, 50));
        applyStimulus(1'b1, 1'b0, 1'b1, beat4(2, 2, 2, 2));
        idle(6);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, i == 0, i == 4, beat4(127, 127, 127, 127));
        end
        applyStimulus(1'b1, 1'b1, 1'b1, beat4(1, 0, 0, 0));
        idle(6);

        applyStimulus(1'b1, 1'b1, 1'b1, beat4(1, 1, 1, 1));
        applyStimulus(1'b1, 1'b1, 1'b1, beat4(2, 2, 2, 2));
        applyStimulus(1'b1, 1'b1, 1'b1, beat4(3, 3, 3, 3));
        idle(6);

        applyStimulus(1'b1, 1'b1, 1'b0, beat4(9, 9, 9, 9));
        applyStimulus(1'b1, 1'b1, 1'b1, beat4(1, 2, 3, 4));
        idle(6);

        applyStimulus(1'b1, 1'b0, 1'b0, beat4(5, 5, 5, 5));
        applyStimulus(1'b1, 1'b0, 1'b0, beat4(5, 5, 5, 5));
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b1, beat4(5, 5, 5, 5));
        idle(6);

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 25, $urandom);
        end
        idle(8);

        checkOutput("dut0_pending", q0.size(), 0);
        checkOutput("dut1_pending", q1.size(), 0);
        checkOutput("dut2_pending", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
